// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_unit_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage for the 16-bit WISC core: owns the PC, talks to a
// variable-latency imem, and feeds decode through the IF/ID register.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_WORD = 16'h0800
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master imem,
   input  logic         redirect_i,
   input  logic [15:0]  redirect_pc_i,
   input  logic         stall_i,
   output logic [15:0]  instr_o,
   output logic [15:0]  pc_o,
   output logic [15:0]  pc_plus_two_o,
   output logic         valid_o,
   output logic         halted_o
);

   typedef enum logic {
      S_REQ    = 1'b0,
      S_HALTED = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] fetch_pc_q, fetch_pc_d;
   logic        squash_q, squash_d;
   logic [15:0] target_pc_q, target_pc_d;
   logic [15:0] buf_instr_q, buf_instr_d;
   logic [15:0] buf_pc_q, buf_pc_d;
   logic        buf_valid_q, buf_valid_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] pcp2_q, pcp2_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;

   logic        req;
   logic        accept;
   logic        load;
   logic [15:0] load_instr;
   logic [15:0] load_pc;

   // A request is outstanding whenever we are fetching and the skid buffer is empty.
   assign req            = (state_q == S_REQ) && !buf_valid_q;
   assign accept         = req && imem.imem_ready;
   assign imem.imem_req  = req;
   assign imem.imem_addr = fetch_pc_q;

   assign instr_o       = instr_q;
   assign pc_o          = pc_q;
   assign pc_plus_two_o = pcp2_q;
   assign valid_o       = valid_q;
   assign halted_o      = halted_q;

   // Next-state: redirect first, then halted hold/drain, then normal fetch/skid/IF-ID update.
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      squash_d    = squash_q;
      target_pc_d = target_pc_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      buf_valid_d = buf_valid_q;
      instr_d     = instr_q;
      pc_d        = pc_q;
      pcp2_d      = pcp2_q;
      valid_d     = valid_q;
      halted_d    = halted_q;
      load        = 1'b0;
      load_instr  = buf_instr_q;
      load_pc     = buf_pc_q;

      if (redirect_i) begin
         valid_d     = 1'b0;
         instr_d     = NOP_WORD;
         buf_valid_d = 1'b0;
         if (state_q == S_HALTED) begin
            state_d    = S_REQ;
            halted_d   = 1'b0;
            fetch_pc_d = redirect_pc_i;
         end else if (accept || !req) begin
            fetch_pc_d = redirect_pc_i;
            squash_d   = 1'b0;
         end else begin
            // Address must stay put until imem answers; remember where to go next.
            squash_d    = 1'b1;
            target_pc_d = redirect_pc_i;
         end
      end else if (state_q == S_HALTED) begin
         if (!stall_i) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
         end
      end else begin
         if (accept) begin
            if (squash_q) begin
               fetch_pc_d = target_pc_q;
               squash_d   = 1'b0;
            end else begin
               fetch_pc_d = fetch_pc_q + 16'd2;
               if (stall_i) begin
                  buf_instr_d = imem.imem_rdata;
                  buf_pc_d    = fetch_pc_q;
                  buf_valid_d = 1'b1;
               end else begin
                  load       = 1'b1;
                  load_instr = imem.imem_rdata;
                  load_pc    = fetch_pc_q;
               end
            end
         end else if (buf_valid_q && !stall_i) begin
            load        = 1'b1;
            buf_valid_d = 1'b0;
         end

         if (!stall_i) begin
            if (load) begin
               instr_d = load_instr;
               pc_d    = load_pc;
               pcp2_d  = load_pc + 16'd2;
               valid_d = 1'b1;
               if (load_instr[15:11] == 5'b00000) begin
                  state_d  = S_HALTED;
                  halted_d = 1'b1;
               end
            end else begin
               valid_d = 1'b0;
               instr_d = NOP_WORD;
            end
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_REQ;
         fetch_pc_q  <= RESET_PC;
         squash_q    <= 1'b0;
         target_pc_q <= '0;
         buf_instr_q <= '0;
         buf_pc_q    <= '0;
         buf_valid_q <= 1'b0;
         instr_q     <= NOP_WORD;
         pc_q        <= '0;
         pcp2_q      <= '0;
         valid_q     <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         squash_q    <= squash_d;
         target_pc_q <= target_pc_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
         buf_valid_q <= buf_valid_d;
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         pcp2_q      <= pcp2_d;
         valid_q     <= valid_d;
         halted_q    <= halted_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table plus randomized run against an
// instruction-stream reference model.
module tb_fetch_unit;
   localparam logic [15:0] NOP = 16'h0800;

   logic        clk;
   logic        rst_n;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        stall;
   logic [15:0] instr;
   logic [15:0] pc;
   logic [15:0] pc_plus_two;
   logic        valid;
   logic        halted;

   int checks;
   int failures;

   fetch_unit_if imem ();

   fetch_unit #(.RESET_PC(16'h0000), .NOP_WORD(NOP)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem          (imem),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .stall_i       (stall),
      .instr_o       (instr),
      .pc_o          (pc),
      .pc_plus_two_o (pc_plus_two),
      .valid_o       (valid),
      .halted_o      (halted)
   );

   initial clk = 1'b0;
   // Free-running clock.
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        redir;
      logic [15:0] rpc;
      logic        stl;
      logic        rdy;
      logic [15:0] rdata;
      logic        chk;
      logic        req;
      logic [15:0] addr;
      logic        v;
      logic [15:0] ins;
      logic [15:0] p;
      logic [15:0] p2;
      logic        h;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic redir, input logic [15:0] rpc,
                               input logic stl, input logic rdy, input logic [15:0] rdata,
                               input logic chk, input logic req, input logic [15:0] addr,
                               input logic v, input logic [15:0] ins, input logic [15:0] p,
                               input logic [15:0] p2, input logic h);
      vec_t r;
      r.rst = rst; r.redir = redir; r.rpc = rpc; r.stl = stl; r.rdy = rdy; r.rdata = rdata;
      r.chk = chk; r.req = req; r.addr = addr; r.v = v; r.ins = ins; r.p = p; r.p2 = p2; r.h = h;
      return r;
   endfunction

   // Program image for the random phase: a HALT word every 32 instructions.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [15:0] hsh;
      hsh = (a * 16'h2F1B) ^ 16'h3C5A;
      if (a[5:1] == 5'h1D) return {5'b00000, a[10:0]};
      return {1'b1, hsh[14:0]};
   endfunction

   task automatic chk(input string name, input int cyc, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
      end
   endtask

   logic [15:0] prev_addr;
   logic [15:0] exp_pc;
   logic [31:0] r32;
   logic        prev_pend;
   logic        redir_prev;
   logic        halt_cons;
   int          halt_cnt;
   int          consumed;
   logic [50:0] got_v;
   logic [50:0] exp_v;

   initial begin
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
      imem.imem_ready = 1'b0; imem.imem_rdata = NOP;
      checks = 0; failures = 0;

      // rst redir rpc stall rdy rdata | chk req addr valid instr pc pc+2 halted
      tbl.push_back(mk(0,0,16'h0000,0,0,NOP,     0,0,16'h0000,0,NOP,    16'h0000,16'h0000,0));
      tbl.push_back(mk(0,0,16'h0000,0,0,NOP,     1,1,16'h0000,0,NOP,    16'h0000,16'h0000,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,NOP,     1,1,16'h0000,0,NOP,    16'h0000,16'h0000,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,NOP,     1,1,16'h0002,1,NOP,    16'h0000,16'h0002,0));
      tbl.push_back(mk(1,0,16'h0000,0,0,NOP,     1,1,16'h0004,1,NOP,    16'h0002,16'h0004,0));
      tbl.push_back(mk(0,0,16'h0000,0,0,NOP,     1,1,16'h0004,0,NOP,    16'h0002,16'h0004,0));
      tbl.push_back(mk(0,0,16'h0000,0,0,NOP,     1,1,16'h0000,0,NOP,    16'h0000,16'h0000,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,NOP,     1,1,16'h0000,0,NOP,    16'h0000,16'h0000,0));
      tbl.push_back(mk(1,0,16'h0000,0,0,NOP,     1,1,16'h0002,1,NOP,    16'h0000,16'h0002,0));
      tbl.push_back(mk(1,0,16'h0000,0,0,NOP,     1,1,16'h0002,0,NOP,    16'h0000,16'h0002,0));
      tbl.push_back(mk(1,0,16'h0000,0,0,NOP,     1,1,16'h0002,0,NOP,    16'h0000,16'h0002,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,16'h8A02,1,1,16'h0002,0,NOP,    16'h0000,16'h0002,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,16'h8A04,1,1,16'h0004,1,16'h8A02,16'h0002,16'h0004,0));
      tbl.push_back(mk(1,1,16'h0040,0,0,NOP,     1,1,16'h0006,1,16'h8A04,16'h0004,16'h0006,0));
      tbl.push_back(mk(1,0,16'h0000,0,0,NOP,     1,1,16'h0006,0,NOP,    16'h0004,16'h0006,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,16'hDEAD,1,1,16'h0006,0,NOP,    16'h0004,16'h0006,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,16'h8A40,1,1,16'h0040,0,NOP,    16'h0004,16'h0006,0));
      tbl.push_back(mk(1,0,16'h0000,1,1,16'h8A42,1,1,16'h0042,1,16'h8A40,16'h0040,16'h0042,0));
      tbl.push_back(mk(1,0,16'h0000,1,1,16'h8A44,1,0,16'h0044,1,16'h8A40,16'h0040,16'h0042,0));
      tbl.push_back(mk(1,0,16'h0000,1,1,16'h8A44,1,0,16'h0044,1,16'h8A40,16'h0040,16'h0042,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,16'h8A44,1,0,16'h0044,1,16'h8A40,16'h0040,16'h0042,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,16'h8A44,1,1,16'h0044,1,16'h8A42,16'h0042,16'h0044,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,16'h0000,1,1,16'h0046,1,16'h8A44,16'h0044,16'h0046,0));
      tbl.push_back(mk(1,0,16'h0000,1,1,NOP,     1,0,16'h0048,1,16'h0000,16'h0046,16'h0048,1));
      tbl.push_back(mk(1,0,16'h0000,0,1,NOP,     1,0,16'h0048,1,16'h0000,16'h0046,16'h0048,1));
      tbl.push_back(mk(1,1,16'h0100,0,1,NOP,     1,0,16'h0048,0,NOP,    16'h0046,16'h0048,1));
      tbl.push_back(mk(1,0,16'h0000,0,1,16'h8B00,1,1,16'h0100,0,NOP,    16'h0046,16'h0048,0));
      tbl.push_back(mk(1,1,16'hFFFE,0,1,16'h8B02,1,1,16'h0102,1,16'h8B00,16'h0100,16'h0102,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,16'h8FFE,1,1,16'hFFFE,0,NOP,    16'h0100,16'h0102,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,16'h8800,1,1,16'h0000,1,16'h8FFE,16'hFFFE,16'h0000,0));
      tbl.push_back(mk(1,1,16'h0200,1,0,NOP,     1,1,16'h0002,1,16'h8800,16'h0000,16'h0002,0));
      tbl.push_back(mk(1,1,16'h0300,0,0,NOP,     1,1,16'h0002,0,NOP,    16'h0000,16'h0002,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,16'hDEAD,1,1,16'h0002,0,NOP,    16'h0000,16'h0002,0));
      tbl.push_back(mk(1,0,16'h0000,0,1,16'h9300,1,1,16'h0300,0,NOP,    16'h0000,16'h0002,0));
      tbl.push_back(mk(1,0,16'h0000,0,0,NOP,     1,1,16'h0302,1,16'h9300,16'h0300,16'h0302,0));

      // Directed phase: each row is one cycle; outputs checked, then that cycle's inputs applied.
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         if (tbl[i].chk) begin
            checks++;
            got_v = {imem.imem_req, imem.imem_addr, valid, instr, pc, halted};
            exp_v = {tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].ins, tbl[i].p, tbl[i].h};
            if (got_v !== exp_v || pc_plus_two !== tbl[i].p2) begin
               failures++;
               $display("FAIL row%0d got req=%b addr=%h v=%b instr=%h pc=%h p2=%h h=%b expected req=%b addr=%h v=%b instr=%h pc=%h p2=%h h=%b",
                        i, imem.imem_req, imem.imem_addr, valid, instr, pc, pc_plus_two, halted,
                        tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].ins, tbl[i].p, tbl[i].p2, tbl[i].h);
            end
         end
         rst_n           = tbl[i].rst;
         redirect        = tbl[i].redir;
         redirect_pc     = tbl[i].rpc;
         stall           = tbl[i].stl;
         imem.imem_ready = tbl[i].rdy;
         imem.imem_rdata = tbl[i].rdata;
      end

      // Random phase: the model tracks the architectural instruction stream decode must see.
      @(negedge clk);
      rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; imem.imem_ready = 1'b0;
      @(negedge clk);
      prev_pend = 1'b0; redir_prev = 1'b0; halt_cons = 1'b0;
      exp_pc = 16'h0000; halt_cnt = 0; consumed = 0; prev_addr = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (prev_pend) begin
            chk("req_hold", c, {15'd0, imem.imem_req}, 16'd1);
            chk("addr_hold", c, imem.imem_addr, prev_addr);
         end
         if (redir_prev) chk("flush_valid", c, {15'd0, valid}, 16'd0);
         if (valid) begin
            chk("pc_plus_two", c, pc_plus_two, pc + 16'd2);
            chk("instr_data", c, instr, mem_word(pc));
            if (instr[15:11] == 5'b00000) chk("halt_flag", c, {15'd0, halted}, 16'd1);
         end else begin
            chk("nop_fill", c, instr, NOP);
         end
         if (halted) chk("halt_noreq", c, {15'd0, imem.imem_req}, 16'd0);
         if (halt_cons) begin
            chk("halt_no_valid", c, {15'd0, valid}, 16'd0);
            chk("halt_stays", c, {15'd0, halted}, 16'd1);
         end

         rst_n    = 1'b1;
         halt_cnt = halted ? halt_cnt + 1 : 0;
         redirect = (halt_cnt > 3) || ($urandom_range(0, 19) == 0);
         r32 = $urandom;
         redirect_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFC : {r32[15:1], 1'b0};
         stall = ($urandom_range(0, 3) == 0);
         imem.imem_ready = ($urandom_range(0, 2) != 0);
         r32 = $urandom;
         imem.imem_rdata = imem.imem_ready ? mem_word(imem.imem_addr) : r32[15:0];

         if (valid && !stall && !redirect) begin
            chk("pc_sequence", c, pc, exp_pc);
            exp_pc = pc + 16'd2;
            consumed++;
            if (instr[15:11] == 5'b00000) halt_cons = 1'b1;
         end
         if (redirect) begin
            exp_pc    = redirect_pc;
            halt_cons = 1'b0;
         end
         redir_prev = redirect;
         prev_pend  = imem.imem_req && !imem.imem_ready;
         prev_addr  = imem.imem_addr;
      end
      chk("throughput", 0, {15'd0, consumed > 300}, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
